// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   write-back and late load responses from the data-memory interface.
//   Loads win by default, but only for a bounded burst while the pipe waits.
//   A load and a pipe result to the same non-zero rd always let the load go
//   first, so the younger pipe value lands last. The write port is registered,
//   with one cycle of latency from grant to rf_we.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   pipe_valid/rd/data/ready   pipeline write-back request channel
//   ld_valid/rd/data/ready     load response request channel
//   rf_we/rf_waddr/rf_wdata    registered regfile write port
//   ld_starved                 burst counter has reached MAX_LD_BURST
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int MAX_LD_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_valid,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    output logic            pipe_ready,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            ld_starved
);

    localparam int               CNT_W   = $clog2(MAX_LD_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LD_BURST);

    logic [CNT_W-1:0] burst_cnt;
    logic             same_rd;
    logic             grant_ld;
    logic             grant_pipe;
    logic             grant_any;
    logic [4:0]       win_rd;
    logic [XLEN-1:0]  win_data;

    // Grant decision: same-rd ordering beats the burst limit, the burst
    // limit beats load priority.
    always_comb begin
        same_rd    = (ld_rd == pipe_rd) && (ld_rd != 5'd0);
        grant_ld   = ld_valid && (!pipe_valid || same_rd || (burst_cnt != CNT_MAX));
        grant_pipe = pipe_valid && !grant_ld;
        grant_any  = grant_ld || grant_pipe;
        win_rd     = grant_ld ? ld_rd   : pipe_rd;
        win_data   = grant_ld ? ld_data : pipe_data;
    end

    // Readies drop as soon as reset asserts, without waiting for an edge.
    assign ld_ready   = grant_ld   && rst_n;
    assign pipe_ready = grant_pipe && rst_n;
    assign ld_starved = (burst_cnt == CNT_MAX);

    // Burst counter: counts load grants only while the pipe is actually waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (!pipe_valid || grant_pipe) begin
            burst_cnt <= '0;
        end else if (grant_ld && (burst_cnt != CNT_MAX)) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end

    // Write-port register. x0 writes are acknowledged but leave the port
    // address/data untouched so a stale value is never mistaken for a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant_any && (win_rd != 5'd0);
            if (grant_any && (win_rd != 5'd0)) begin
                rf_waddr <= win_rd;
                rf_wdata <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int XLEN = 32;
    localparam int MAXB = 4;

    logic            clk;
    logic            rst_n;
    logic            pipe_valid;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            pipe_ready;
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            ld_starved;

    int npass  = 0;
    int ntotal = 0;

    // Reference model state (rule level, not cycle-encoded like the RTL)
    int              mcnt;
    logic            m_we;
    logic [4:0]      m_waddr;
    logic [XLEN-1:0] m_wdata;

    wb_port_arbiter #(.XLEN(XLEN), .MAX_LD_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ld_starved(ld_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0 = nobody, 1 = pipe, 2 = load, straight from the priority list
    function automatic int exp_grant();
        if (!pipe_valid && !ld_valid) return 0;
        if (pipe_valid && !ld_valid) return 1;
        if (ld_valid && !pipe_valid) return 2;
        if (ld_rd == pipe_rd && ld_rd != 5'd0) return 2;
        if (mcnt == MAXB) return 1;
        return 2;
    endfunction

    function automatic void model_reset();
        mcnt = 0; m_we = 1'b0; m_waddr = 5'd0; m_wdata = '0;
    endfunction

    // Called at posedge+1; leaves the bench at the following negedge.
    task automatic apply(input logic pv, input logic [4:0] prd, input logic [XLEN-1:0] pd,
                         input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldd);
        pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
        ld_valid = lv; ld_rd = lrd; ld_data = ldd;
        #4;
    endtask

    // Advances one clock edge and updates the model; leaves the bench at posedge+1.
    task automatic tick();
        int g;
        int nc;
        logic [4:0]      rd;
        logic [XLEN-1:0] d;
        g  = exp_grant();
        rd = (g == 2) ? ld_rd : pipe_rd;
        d  = (g == 2) ? ld_data : pipe_data;
        if (!pipe_valid || g == 1) nc = 0;
        else if (g == 2 && mcnt < MAXB) nc = mcnt + 1;
        else nc = mcnt;
        @(posedge clk); #1;
        m_we = (g != 0) && (rd != 5'd0);
        if (m_we) begin m_waddr = rd; m_wdata = d; end
        mcnt = nc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        ntotal++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %0h expected 0", rf_we); else npass++;
        ntotal++; if (rf_waddr !== 5'd0) $display("FAIL reset_waddr: got %0h expected 0", rf_waddr); else npass++;
        ntotal++; if (rf_wdata !== 32'd0) $display("FAIL reset_wdata: got %0h expected 0", rf_wdata); else npass++;
        ntotal++; if (ld_starved !== 1'b0) $display("FAIL reset_starved: got %0h expected 0", ld_starved); else npass++;
        rst_n = 1'b1;
    endtask

    task automatic test_pipe_only(input string tag);
        apply(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
        ntotal++; if (pipe_ready !== 1'b1) $display("FAIL %s_pipe_ready: got %0h expected 1", tag, pipe_ready); else npass++;
        ntotal++; if (ld_ready !== 1'b0) $display("FAIL %s_ld_ready: got %0h expected 0", tag, ld_ready); else npass++;
        tick();
        ntotal++; if (rf_we !== 1'b1) $display("FAIL %s_we: got %0h expected 1", tag, rf_we); else npass++;
        ntotal++; if (rf_waddr !== 5'd5) $display("FAIL %s_waddr: got %0h expected 5", tag, rf_waddr); else npass++;
        ntotal++; if (rf_wdata !== 32'h1234) $display("FAIL %s_wdata: got %0h expected 1234", tag, rf_wdata); else npass++;
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        ntotal++; if (rf_we !== 1'b0) $display("FAIL %s_idle_we: got %0h expected 0", tag, rf_we); else npass++;
    endtask

    task automatic test_burst();
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        for (int c = 0; c < 6; c++) begin
            apply(1'b1, 5'd7, 32'h7777, 1'b1, 5'd3, 32'h3000 + c);
            ntotal++; if (ld_ready !== (c != 4)) $display("FAIL burst_ld_ready_c%0d: got %0h expected %0h", c, ld_ready, (c != 4)); else npass++;
            ntotal++; if (pipe_ready !== (c == 4)) $display("FAIL burst_pipe_ready_c%0d: got %0h expected %0h", c, pipe_ready, (c == 4)); else npass++;
            ntotal++; if (ld_starved !== (c == 4)) $display("FAIL burst_starved_c%0d: got %0h expected %0h", c, ld_starved, (c == 4)); else npass++;
            tick();
            ntotal++; if (rf_waddr !== ((c == 4) ? 5'd7 : 5'd3)) $display("FAIL burst_waddr_c%0d: got %0h expected %0h", c, rf_waddr, ((c == 4) ? 5'd7 : 5'd3)); else npass++;
        end
    endtask

    task automatic test_same_rd();
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        for (int c = 0; c < 4; c++) begin
            apply(1'b1, 5'd7, 32'h7777, 1'b1, 5'd3, 32'h3000 + c);
            tick();
        end
        apply(1'b1, 5'd9, 32'hBBBB0009, 1'b1, 5'd9, 32'hAAAA0009);
        ntotal++; if (ld_starved !== 1'b1) $display("FAIL samerd_starved: got %0h expected 1", ld_starved); else npass++;
        ntotal++; if (ld_ready !== 1'b1) $display("FAIL samerd_ld_ready: got %0h expected 1", ld_ready); else npass++;
        ntotal++; if (pipe_ready !== 1'b0) $display("FAIL samerd_pipe_ready: got %0h expected 0", pipe_ready); else npass++;
        tick();
        ntotal++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) $display("FAIL samerd_first_addr: got we=%0h addr=%0h expected we=1 addr=9", rf_we, rf_waddr); else npass++;
        ntotal++; if (rf_wdata !== 32'hAAAA0009) $display("FAIL samerd_first_data: got %0h expected aaaa0009", rf_wdata); else npass++;
        apply(1'b1, 5'd9, 32'hBBBB0009, 1'b0, 5'd0, 32'h0);
        ntotal++; if (pipe_ready !== 1'b1) $display("FAIL samerd_pipe_second: got %0h expected 1", pipe_ready); else npass++;
        tick();
        ntotal++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) $display("FAIL samerd_second_addr: got we=%0h addr=%0h expected we=1 addr=9", rf_we, rf_waddr); else npass++;
        ntotal++; if (rf_wdata !== 32'hBBBB0009) $display("FAIL samerd_second_data: got %0h expected bbbb0009", rf_wdata); else npass++;
    endtask

    task automatic test_x0();
        apply(1'b1, 5'd12, 32'hCAFE, 1'b0, 5'd0, 32'h0);
        tick();
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
        ntotal++; if (ld_ready !== 1'b1) $display("FAIL x0_ld_ready: got %0h expected 1", ld_ready); else npass++;
        tick();
        ntotal++; if (rf_we !== 1'b0) $display("FAIL x0_we: got %0h expected 0", rf_we); else npass++;
        ntotal++; if (rf_waddr !== 5'd12) $display("FAIL x0_waddr_hold: got %0h expected c", rf_waddr); else npass++;
        ntotal++; if (rf_wdata !== 32'hCAFE) $display("FAIL x0_wdata_hold: got %0h expected cafe", rf_wdata); else npass++;
    endtask

    task automatic test_reset_midstream();
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        apply(1'b1, 5'd7, 32'h7777, 1'b1, 5'd3, 32'h3333);
        tick();
        apply(1'b1, 5'd7, 32'h7777, 1'b1, 5'd3, 32'h3334);
        ntotal++; if (ld_ready !== 1'b1) $display("FAIL rstmid_pre_ld_ready: got %0h expected 1", ld_ready); else npass++;
        rst_n = 1'b0;
        #1;
        ntotal++; if (ld_ready !== 1'b0 || pipe_ready !== 1'b0) $display("FAIL rstmid_readies: got ld=%0h pipe=%0h expected 0 0", ld_ready, pipe_ready); else npass++;
        ntotal++; if (rf_we !== 1'b0) $display("FAIL rstmid_we: got %0h expected 0", rf_we); else npass++;
        ntotal++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) $display("FAIL rstmid_port: got addr=%0h data=%0h expected 0 0", rf_waddr, rf_wdata); else npass++;
        pipe_valid = 1'b0; ld_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        test_pipe_only("rstmid_after");
    endtask

    task automatic test_pipe_drop();
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, 5'd7, 32'h7777, 1'b1, 5'd3, 32'h5000 + c);
            tick();
        end
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h5002);
        ntotal++; if (ld_ready !== 1'b1) $display("FAIL drop_ld_ready: got %0h expected 1", ld_ready); else npass++;
        tick();
        for (int c = 0; c < 5; c++) begin
            apply(1'b1, 5'd7, 32'h7777, 1'b1, 5'd3, 32'h6000 + c);
            ntotal++; if (ld_ready !== (c < 4)) $display("FAIL drop_ld_ready_c%0d: got %0h expected %0h", c, ld_ready, (c < 4)); else npass++;
            ntotal++; if (pipe_ready !== (c == 4)) $display("FAIL drop_pipe_ready_c%0d: got %0h expected %0h", c, pipe_ready, (c == 4)); else npass++;
            tick();
        end
    endtask

    task automatic test_random();
        int g;
        logic p_pend, l_pend;
        logic            pv, lv;
        logic [4:0]      prd, lrd;
        logic [XLEN-1:0] pd, ldd;
        p_pend = 1'b0; l_pend = 1'b0;
        pv = 1'b0; lv = 1'b0; prd = '0; lrd = '0; pd = '0; ldd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p_pend) begin
                pv = ($urandom_range(0, 3) != 0); prd = 5'($urandom_range(0, 7)); pd = $urandom;
            end
            if (!l_pend) begin
                lv = ($urandom_range(0, 4) != 0); lrd = 5'($urandom_range(0, 7)); ldd = $urandom;
            end
            apply(pv, prd, pd, lv, lrd, ldd);
            g = exp_grant();
            ntotal++; if (pipe_ready !== (g == 1)) $display("FAIL rand_pipe_ready_%0d: got %0h expected %0h", i, pipe_ready, (g == 1)); else npass++;
            ntotal++; if (ld_ready !== (g == 2)) $display("FAIL rand_ld_ready_%0d: got %0h expected %0h", i, ld_ready, (g == 2)); else npass++;
            ntotal++; if (ld_starved !== (mcnt == MAXB)) $display("FAIL rand_starved_%0d: got %0h expected %0h", i, ld_starved, (mcnt == MAXB)); else npass++;
            p_pend = pv && (g != 1);
            l_pend = lv && (g != 2);
            tick();
            ntotal++; if (rf_we !== m_we) $display("FAIL rand_we_%0d: got %0h expected %0h", i, rf_we, m_we); else npass++;
            ntotal++; if (rf_waddr !== m_waddr || rf_wdata !== m_wdata) $display("FAIL rand_port_%0d: got %0h/%0h expected %0h/%0h", i, rf_waddr, rf_wdata, m_waddr, m_wdata); else npass++;
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_pipe_only("pipe_only");
        test_burst();
        test_same_rd();
        test_x0();
        test_reset_midstream();
        test_pipe_drop();
        test_random();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
